vga_sync: RTL and testbench

- Pixel-timing generator that drives the graphics renderer's pixel interface: pix_x, pix_y, video_on, plus hsync/vsync to the VGA connector.
- Divides the system clock into a pixel tick and runs horizontal and vertical counters over a full 640x480 frame, including blanking.
- Gates the renderer's 3-bit colour onto the output during the active area.

---
 rtl/vga_sync.sv | 113 +++++++++++
 tb/tb_vga_sync.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync.sv
// 640x480 VGA pixel-timing generator: pixel divider, h/v counters, registered sync/blank decode.
// Optional VGA_RGB_PIPE_EN adds a one-pixel output stage with registered rgb_out.
module vga_sync #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int PIX_DIV   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rgb_in,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic [2:0] rgb_out
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_DISPLAY);
  localparam logic [9:0] V_ACT  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt, v_cnt, h_nxt, v_nxt;
  logic             hs_r, vs_r, von_r, fs_r;

  assign p_tick = (div_cnt == DIV_MAX);

  always_comb begin
    h_nxt = h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_MAX) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_MAX) ? '0 : v_cnt + 10'd1;
    end
  end

  // Decode is taken from the next counter values so the registered flags line up with pix_x/pix_y.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      h_cnt   <= H_MAX;
      v_cnt   <= V_MAX;
      hs_r    <= 1'b1;
      vs_r    <= 1'b1;
      von_r   <= 1'b0;
      fs_r    <= 1'b0;
    end else begin
      div_cnt <= p_tick ? '0 : div_cnt + DIV_W'(1);
      fs_r    <= 1'b0;
      if (p_tick) begin
        h_cnt <= h_nxt;
        v_cnt <= v_nxt;
        hs_r  <= !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
        vs_r  <= !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
        von_r <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
        fs_r  <= (h_nxt == '0) && (v_nxt == '0);
      end
    end
  end

  assign pix_x       = h_cnt;
  assign pix_y       = v_cnt;
  assign frame_start = fs_r;

`ifdef VGA_RGB_PIPE_EN
  logic       hs_d, vs_d, von_d;
  logic [2:0] rgb_q;

  // rgb_in belongs to the pixel now ending, so its colour and flags show during the next pixel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
      von_d <= 1'b0;
      rgb_q <= 3'b000;
    end else if (p_tick) begin
      hs_d  <= hs_r;
      vs_d  <= vs_r;
      von_d <= von_r;
      rgb_q <= von_r ? rgb_in : 3'b000;
    end
  end

  assign hsync    = hs_d;
  assign vsync    = vs_d;
  assign video_on = von_d;
  assign rgb_out  = rgb_q;
`else
  assign hsync    = hs_r;
  assign vsync    = vs_r;
  assign video_on = von_r;
  assign rgb_out  = von_r ? rgb_in : 3'b000;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: full horizontal timing with a shortened vertical frame so a whole
// frame plus a mid-frame reset fits in a short run; expected outputs come from the pixel index.
module tb_vga_sync;
  localparam int PD = 2;
  localparam int HD = 640, HF = 16, HS = 96, HB = 48;
  localparam int VD = 4, VF = 2, VS = 2, VB = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME = HT * VT * PD;
`ifdef VGA_RGB_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] rgb_in = 3'b101;
  logic       p_tick, video_on, hsync, vsync, frame_start;
  logic [9:0] pix_x, pix_y;
  logic [2:0] rgb_out;

  always #5 clk = ~clk;

  vga_sync #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIX_DIV(PD)
  ) dut (
    .clk(clk), .reset(reset), .rgb_in(rgb_in), .p_tick(p_tick),
    .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on), .hsync(hsync),
    .vsync(vsync), .frame_start(frame_start), .rgb_out(rgb_out)
  );

  typedef struct {
    string       tag;
    logic [27:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          tog = 1'b0;
  logic [27:0] obs;

  assign obs = {p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_start, rgb_out};

  function automatic logic [2:0] col(int k);
    if (!tog) return 3'b101;
    return k[0] ? 3'b110 : 3'b011;
  endfunction

  // {video_on, hsync, vsync, rgb} for linear pixel index kk
  function automatic logic [5:0] sig(int kk);
    int xx, yy;
    logic von, hs, vs;
    xx  = kk % HT;
    yy  = (kk / HT) % VT;
    von = (xx < HD) && (yy < VD);
    hs  = !((xx >= HD + HF) && (xx < HD + HF + HS));
    vs  = !((yy >= VD + VF) && (yy < VD + VF + VS));
    return {von, hs, vs, von ? col(kk) : 3'b000};
  endfunction

  // c = clks since pixel (0,0) began; -1 = gap after reset release, -2 = reset held
  function automatic logic [27:0] model(int c);
    int k;
    logic pt, fs;
    logic [5:0] s;
    if (c < 0) return {c == -1, 10'(HT - 1), 10'(VT - 1), 1'b0, 1'b1, 1'b1, 1'b0, 3'b000};
    k  = c / PD;
    pt = ((c + 1) % PD) == 0;
    fs = ((k % (HT * VT)) == 0) && ((c % PD) == 0);
    if (PIPE) s = (k == 0) ? 6'b011000 : sig(k - 1);
    else      s = sig(k);
    return {pt, 10'(k % HT), 10'((k / HT) % VT), s[5], s[4], s[3], fs, s[2:0]};
  endfunction

  task automatic push(string tag, logic [27:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty obs=%h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      n_err++;
      $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic chk(string tag, int o, int e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s obs=%0d exp=%0d", tag, o, e);
    end
  endtask

  task automatic cyc(int c, string tag);
    @(posedge clk);
    #1;
    rgb_in = col((c < 0) ? 0 : c / PD);
    push(tag, model(c));
    #1;
    check_pop();
  endtask

  initial begin
    int hs_low, von_cnt, vs_low, max_x, max_y;
    int hs_f1, hs_f2, hs_x, vs_f1, vs_y, fs1, fs2;
    int k_tgt;
    logic prev_hs, prev_vs;
    hs_low = 0; von_cnt = 0; vs_low = 0; max_x = 0; max_y = 0;
    hs_f1 = -1; hs_f2 = -1; hs_x = -1; vs_f1 = -1; vs_y = -1; fs1 = -1; fs2 = -1;
    prev_hs = 1'b1; prev_vs = 1'b1;

    for (int i = 0; i < 5; i++) cyc(-2, "reset_idle");
    reset = 1'b1;
    cyc(-1, "prestart");

    k_tgt = HT * VT + (VD + VF + 1) * HT + 700;
    for (int c = 0; c <= k_tgt * PD; c++) begin
      cyc(c, "frame_run");
      if (c < FRAME && pix_y == 10'd0 && !hsync) hs_low++;
      if (c < FRAME && pix_y == 10'd0 && video_on) von_cnt++;
      if (c < FRAME && !vsync) vs_low++;
      if (prev_hs && !hsync) begin
        if (hs_f1 < 0) begin hs_f1 = c; hs_x = int'(pix_x); end
        else if (hs_f2 < 0) hs_f2 = c;
      end
      if (prev_vs && !vsync && vs_f1 < 0) begin vs_f1 = c; vs_y = int'(pix_y); end
      if (frame_start) begin
        if (fs1 < 0) fs1 = c;
        else if (fs2 < 0) fs2 = c;
      end
      if (int'(pix_x) > max_x) max_x = int'(pix_x);
      if (int'(pix_y) > max_y) max_y = int'(pix_y);
      prev_hs = hsync;
      prev_vs = vsync;
    end

    chk("fs_first_clk", fs1, 0);
    chk("hs_low_clks", hs_low, HS * PD);
    chk("hs_start_x", hs_x, PIPE ? HD + HF + 1 : HD + HF);
    chk("line_period", hs_f2 - hs_f1, HT * PD);
    chk("von_clks", von_cnt, HD * PD);
    chk("vs_low_clks", vs_low, VS * HT * PD);
    chk("vs_start_y", vs_y, VD + VF);
    chk("frame_period", fs2 - fs1, FRAME);
    chk("max_x", max_x, HT - 1);
    chk("max_y", max_y, VT - 1);
    chk("mid_x", int'(pix_x), 700);
    chk("mid_y", int'(pix_y), VD + VF + 1);
    chk("mid_in_hsync", int'(hsync), 0);
    chk("mid_in_vsync", int'(vsync), 0);

    reset = 1'b0;
    cyc(-2, "midframe_reset");
    cyc(-2, "midframe_reset_hold");
    reset = 1'b1;
    tog = 1'b1;
    cyc(-1, "resync_prestart");
    for (int c = 0; c < 2 * HT * PD; c++) cyc(c, "resync_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
